skid_buffer: RTL and testbench
==============================

// Module: skid_buffer
// PURPOSE
//  Two-entry valid/ready pipeline stage (skid buffer).
//  Feeds the enable-gated data registers (register_en) on the next stage.
//  Breaks the combinational ready path between producer and consumer.
//  Sustains one transfer per cycle with one cycle of latency.
// PARAMETERS
//  WIDTH  1  payload width in bits
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      producer has a beat on in_data
//  in_ready   out  1      buffer can accept a beat this cycle (registered)
//  in_data    in   WIDTH  producer payload
//  out_valid  out  1      out_data holds a valid beat (registered)
//  out_ready  in   1      consumer accepts the beat this cycle
//  out_data   out  WIDTH  payload to the consumer (registered)
//  occupancy  out  2      number of beats held: 0, 1 or 2
// BEHAVIOUR
//  - Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - No combinational path from any input to any output.
//  - Reset (rst_n low, asynchronous):
//    - state = EMPTY, out_valid = 0, in_ready = 0, occupancy = 0.
//    - Buffered beats are discarded, including a reset asserted mid-transfer.
//    - in_ready rises on the first clk edge after rst_n deasserts.
//  - States:
//    - EMPTY: main and skid both empty.
//    - BUSY: main holds one beat.
//    - FULL: main and skid both hold a beat.
//  - Outputs by state: out_valid = (state != EMPTY); in_ready = (state != FULL);
//    occupancy = 0 / 1 / 2. All are driven from flops.
//  - Transitions:
//    - EMPTY, in_fire: main <= in_data, go to BUSY.
//    - BUSY, in_fire and no out_fire: skid <= in_data, go to FULL.
//    - BUSY, out_fire and no in_fire: go to EMPTY.
//    - BUSY, in_fire and out_fire together: main <= in_data, stay in BUSY.
//    - FULL, out_fire: main <= skid, go to BUSY. No in_fire is possible in FULL.
//    - Any other case: hold state and data.
//  - out_data is always main.
//  - Latency: a beat accepted at edge N is visible on out_data after edge N.
//    It can leave at edge N+1.
//  - Ordering: strict FIFO. No beat is dropped or duplicated.
//  - Stability: while out_valid & !out_ready, out_valid and out_data are held.
//  - in_valid while in_ready = 0 is ignored. Upstream must hold the beat.
//  - out_data is don't-care while out_valid = 0. The data registers have no reset.
//  - The bench must not check out_data when out_valid = 0.
// STRUCTURE
//  - Package svlib_skid_pkg: typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t.
//  - Next-state logic, occupancy and in_ready/out_valid flops live in skid_buffer.
//  - Two register_en instances (WIDTH) hold main and skid.
//    - main: en = load_main, din = FULL ? skid : in_data.
//    - skid: en = load_skid.
//  - SVA: in_ready & out_valid never both 0 after reset; occupancy <= 2.
// TESTING
//  1. Reset, then in_valid=1 with in_data=0xA5 and out_ready=1.
//     -> out_valid=1 and out_data=0xA5 one cycle later; occupancy=1.
//  2. Streaming 1..16 back-to-back with out_ready=1.
//     -> out_data = 1..16 in consecutive cycles; in_ready stays 1.
//  3. Push 0x11, 0x22 with out_ready=0.
//     -> occupancy=2, in_ready=0, out_data held at 0x11.
//     Raise out_ready -> out 0x11, then 0x22; in_ready=1 after the first pop.
//  4. Random in_valid/out_ready at 50% over 10k beats.
//     -> scoreboard order exact; no beat lost or duplicated.
//  5. Assert rst_n mid-stream while FULL.
//     -> out_valid=0, occupancy=0 immediately.
//     After release: in_ready=1 next edge; old beats never appear.
//  6. In BUSY, fire in and out together (0x33 in, 0x22 out).
//     -> stays BUSY; out_data=0x33 next cycle; occupancy stays 1.

Source files
------------

// File: rtl/svlib_skid_pkg.sv
// Shared types for the skid buffer: FSM state encoding and the state-to-occupancy mapping.
package svlib_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] occ_of(skid_state_t s);
        logic [1:0] occ;
        case (s)
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/register_en.sv
// Enable-gated data register without reset; holds its value while en_i is low.
module register_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: every output comes from a flop, so no input
// reaches an output combinationally. out_data is always the main register.
module skid_buffer
    import svlib_skid_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    skid_state_t      state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [1:0]       occ_q;
    logic             in_fire, out_fire;
    logic             load_main, load_skid;
    logic [WIDTH-1:0] main_din, main_q, skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && !out_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_fire && !in_fire) begin
                    state_d   = EMPTY;
                end else if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (out_fire) begin
                    load_main = 1'b1;
                    state_d   = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // in_ready stays low for the first edge after reset, then tracks !FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= occ_of(state_d);
        end
    end

    assign main_din = (state_q == FULL) ? skid_q : in_data;

    register_en #(.WIDTH(WIDTH)) u_main (
        .clk_i (clk),
        .en_i  (load_main),
        .d_i   (main_din),
        .q_o   (main_q)
    );

    register_en #(.WIDTH(WIDTH)) u_skid (
        .clk_i (clk),
        .en_i  (load_skid),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

    a_never_stalled_both : assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> (in_ready_q || out_valid_q));

    a_occ_max : assert property (@(posedge clk) disable iff (!rst_n)
        occ_q <= 2'd2);

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed scenarios plus random traffic against a queue model.
module tb_skid_buffer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    skid_buffer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: beats held in arrival order, plus "ready allowed" flag
    // that is clear for the first edge after reset.
    logic [W-1:0] exp_q[$];
    bit           rdy_ok = 1'b0;
    string        cur_tag = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check({cur_tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
        check({cur_tag, ".in_ready"}, 32'(in_ready), 32'(rdy_ok && exp_q.size() < 2));
        check({cur_tag, ".occupancy"}, 32'(occupancy), 32'(exp_q.size()));
        if (exp_q.size() > 0) check({cur_tag, ".out_data"}, 32'(out_data), 32'(exp_q[0]));
    endtask

    // Called just after a negedge: drive, clock once, update model, check at negedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, output bit fired);
        bit exp_rdy, exp_vld;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        exp_rdy = rdy_ok && (exp_q.size() < 2);
        exp_vld = (exp_q.size() > 0);
        @(posedge clk);
        fired = v && exp_rdy;
        if (r && exp_vld) void'(exp_q.pop_front());
        if (fired) exp_q.push_back(d);
        rdy_ok = 1'b1;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        rdy_ok = 1'b0;
        check({tag, ".rst_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".rst_occupancy"}, 32'(occupancy), 32'd0);
        check({tag, ".rst_in_ready"}, 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit           f;
        bit           cur_v;
        logic [W-1:0] cur_d;
        int           beats;
        int           cycles;

        apply_reset("t1");

        cur_tag = "t1";
        step(1'b1, 8'hA5, 1'b1, f);   // in_ready still low: not accepted
        check("t1.first_edge_no_accept", 32'(f), 32'd0);
        step(1'b1, 8'hA5, 1'b1, f);
        check("t1.accepted", 32'(f), 32'd1);
        check("t1.data_a5", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, f);

        cur_tag = "t2";
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, W'(i), 1'b1, f);
            check("t2.stream_data", 32'(out_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, f);

        cur_tag = "t3";
        step(1'b1, 8'h11, 1'b0, f);
        step(1'b1, 8'h22, 1'b0, f);
        check("t3.full_occ", 32'(occupancy), 32'd2);
        step(1'b0, 8'h00, 1'b0, f);
        check("t3.held_data", 32'(out_data), 32'h11);
        step(1'b0, 8'h00, 1'b1, f);
        check("t3.second_out", 32'(out_data), 32'h22);
        check("t3.ready_after_pop", 32'(in_ready), 32'd1);
        step(1'b0, 8'h00, 1'b1, f);

        cur_tag = "t6";
        step(1'b1, 8'h22, 1'b0, f);
        step(1'b1, 8'h33, 1'b1, f);
        check("t6.data_33", 32'(out_data), 32'h33);
        check("t6.occ_1", 32'(occupancy), 32'd1);
        step(1'b0, 8'h00, 1'b1, f);

        cur_tag = "t4";
        beats  = 0;
        cycles = 0;
        cur_v  = 1'b0;
        cur_d  = '0;
        while (beats < 10000 && cycles < 60000) begin
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 1) == 1);
                cur_d = W'($urandom);
            end
            step(cur_v, cur_d, ($urandom_range(0, 1) == 1), f);
            if (f) begin
                beats++;
                cur_v = 1'b0;
            end
            cycles++;
        end
        check("t4.beat_budget", 32'(beats), 32'd10000);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 10) begin
            step(1'b0, 8'h00, 1'b1, f);
            cycles++;
        end
        check("t4.drained", 32'(exp_q.size()), 32'd0);

        cur_tag = "t5";
        step(1'b1, 8'hC1, 1'b0, f);
        step(1'b1, 8'hC2, 1'b0, f);
        check("t5.full_before_reset", 32'(occupancy), 32'd2);
        apply_reset("t5");
        step(1'b0, 8'h00, 1'b0, f);
        check("t5.ready_after_release", 32'(in_ready), 32'd1);
        step(1'b1, 8'h5A, 1'b0, f);
        check("t5.new_beat_only", 32'(out_data), 32'h5A);
        step(1'b0, 8'h00, 1'b1, f);
        check("t5.empty_after", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
